clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Parametrised multi-channel clock-enable and divided-clock generator running from the single PLL output clock. Each channel produces a square wave and a one-cycle period strobe at a programmable integer division of `clk`. Divisors are reprogrammable at run time, with glitch-free changeover at period boundaries. A global sync re-aligns the phase of all channels. It sits directly behind the PLL and feeds baud, PWM and sample-rate logic.

## Interface
Parameters:
- `NUM_CH`, 4, number of independent channels (1–16).
- `CNT_W`, 16, divisor/counter width in bits.
- `DEFAULT_DIV`, 12, divisor loaded into every channel at reset.

Ports:
- `clk`  in  1  system clock (PLL output); all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  NUM_CH  per-channel run enable.
- `sync`  in  1  single-cycle pulse; phase-aligns all enabled channels.
- `div_load`  in  1  single-cycle write strobe for a divisor.
- `div_ch`  in  clog2(NUM_CH) (min 1)  channel index for `div_load`.
- `div_val`  in  CNT_W  new divisor (period in `clk` cycles).
- `dout`  out  NUM_CH  divided square wave per channel.
- `tick`  out  NUM_CH  one-cycle strobe at start of each period.
- `pending`  out  NUM_CH  shadow divisor written but not yet active.

## Operation
- Per channel state: counter `cnt` (CNT_W), active divisor `P`, shadow divisor `S`, `pending` flag.
- Divisor clamp: written values below 2 are stored as 2. Maximum is 2^CNT_W−1.
- Channel disabled (`en`=0):
  - `cnt`=0, `dout`=0, `tick`=0.
  - If `pending`, `P`←`S` and `pending` clears on the next edge.
- Channel running: `cnt` counts 0…P−1, then wraps.
  - `tick`=1 in the cycle `cnt`==0.
  - `dout`=1 while `cnt` < floor(P/2), else 0. Odd P therefore gives a shorter high phase (P=3 gives 1 high, 2 low).
- Divisor write: `div_load`=1 writes the clamped `div_val` into `S[div_ch]` and sets `pending`. `div_ch` ≥ NUM_CH is ignored.
- Changeover: on the edge where a running channel wraps (`cnt`==P−1), `P`←`S` if `pending`, and `pending` clears. The new period begins with the wrap. No truncated or stretched period.
- `sync`: every enabled channel forces `cnt`←0 (`tick`=1, `dout`=1 next cycle) and applies any pending shadow. Disabled channels are unaffected.

## Timing
- Reset values:
  - `cnt`=0; `P`=`S`=clamp(DEFAULT_DIV).
  - `dout`=0, `tick`=0, `pending`=0.
- All outputs are registered; no combinational input-to-output path.
- Enable latency: `en` sampled high at edge n (was low) gives `cnt`=0, `tick`=1, `dout`=1 after edge n.
- `en` dropping mid-period: outputs go low after the next edge. No completion of the period.
- Load on the same edge as a wrap of that channel: the loaded value becomes `P` immediately, and `pending` stays 0.
- Load together with `sync`: same rule, applied to enabled channels. Disabled channels get `pending`=1 and apply it the following cycle.
- Load on the same edge as a `pending` clear for another channel: independent, no interaction.
- Two loads to one channel before a wrap: the last value wins; the intermediate value is never active.
- `rst_n` asserted mid-period: all state returns to reset values immediately (asynchronous). The first `tick` after release needs `en` high at an edge.

## Structure
- Package `clk_div_pkg` holds:
  - `MIN_DIV`=2.
  - The `clamp_div` function.
  - The channel-index width function (clog2 with minimum 1).
- Sub-module `clk_div_ch` implements one channel (`cnt`, `P`, `S`, `pending`, `dout`, `tick`). The top level does write-address decode and a generate loop over NUM_CH.

## Test plan
- Reset, `en`=4'b0001, DEFAULT_DIV=12:
  - `tick[0]` every 12 cycles, first one 1 cycle after `en`.
  - `dout[0]` 6 high / 6 low.
  - Channels 1–3 held 0.
- Load ch0 `div_val`=5 mid-period:
  - `pending[0]`=1 until the current 12-cycle period ends.
  - Then period 5 with `dout` 2 high / 3 low; `pending` clears at the wrap.
- Load with `div_val`=0 and `div_val`=1: channel runs at period 2 (`dout` toggles every cycle, `tick` every 2 cycles).
- Channels 0/1 at divisors 7/10, both enabled, with `sync` pulsed at an arbitrary cycle: both `tick`s assert together one cycle later and then keep their own periods. Load ch1 with 3 in the same cycle as `sync`: the new period starts at the sync.
- `div_ch`=NUM_CH with `div_load`: no `pending` or divisor change on any channel.
- `rst_n` low for 1 cycle mid-period with loads pending: all outputs 0 immediately, divisors back to 12, `pending`=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider/enable generator.
//   MIN_DIV   : smallest usable divisor (period in clk cycles)
//   idx_w     : channel-index width, clog2 with a floor of 1 bit
//   clamp_div : raises divisors below MIN_DIV to MIN_DIV
package clk_div_pkg;

   localparam int unsigned MIN_DIV = 2;

   // Channel-index width; a single channel still needs a 1-bit index port.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Divisors 0 and 1 cannot produce a square wave, so store them as MIN_DIV.
   function automatic logic [31:0] clamp_div(input logic [31:0] v);
      return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow divisor, pending flag and
// registered square-wave/strobe outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable
//   sync       : phase re-align strobe
//   load       : divisor write strobe for this channel
//   load_val   : raw divisor value (clamped here)
//   dout       : divided square wave
//   tick       : one-cycle strobe at period start
//   pending    : shadow divisor waiting for a period boundary
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             dout,
   output logic             tick,
   output logic             pending
);

   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(clamp_div(32'(DEFAULT_DIV)));

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] per, per_nxt;
   logic [CNT_W-1:0] shd, shd_nxt;
   logic             run, run_nxt;
   logic             pend_nxt, dout_nxt, tick_nxt;
   logic [CNT_W-1:0] load_clamped;
   logic [CNT_W-1:0] eff_shd;
   logic             eff_pend;

   assign load_clamped = CNT_W'(clamp_div(32'(load_val)));
   // A load on a boundary edge takes effect at that same boundary.
   assign eff_shd      = load ? load_clamped : shd;
   assign eff_pend     = load | pending;

   // Next-state and next-output logic.
   always_comb begin
      cnt_nxt  = cnt;
      per_nxt  = per;
      shd_nxt  = shd;
      pend_nxt = pending;
      run_nxt  = run;
      dout_nxt = 1'b0;
      tick_nxt = 1'b0;

      if (!en) begin
         // Idle: hold counter at zero; a pending divisor written earlier
         // is applied now, a fresh write waits one more cycle.
         cnt_nxt  = '0;
         run_nxt  = 1'b0;
         if (pending) per_nxt = shd;
         if (load) shd_nxt = load_clamped;
         pend_nxt = load;
      end else if (!run || sync || (cnt == per - CNT_W'(1))) begin
         // Period boundary: start, re-align or natural wrap.
         cnt_nxt  = '0;
         run_nxt  = 1'b1;
         tick_nxt = 1'b1;
         dout_nxt = 1'b1;
         shd_nxt  = eff_shd;
         if (eff_pend) per_nxt = eff_shd;
         pend_nxt = 1'b0;
      end else begin
         cnt_nxt  = cnt + CNT_W'(1);
         dout_nxt = (cnt_nxt < (per >> 1));
         if (load) begin
            shd_nxt  = load_clamped;
            pend_nxt = 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         per     <= RST_DIV;
         shd     <= RST_DIV;
         run     <= 1'b0;
         pending <= 1'b0;
         dout    <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         per     <= per_nxt;
         shd     <= shd_nxt;
         run     <= run_nxt;
         pending <= pend_nxt;
         dout    <= dout_nxt;
         tick    <= tick_nxt;
      end
   end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator.
//   clk, rst_n : PLL clock, asynchronous active-low reset
//   en         : per-channel run enable
//   sync       : phase-aligns all enabled channels
//   div_load   : divisor write strobe
//   div_ch     : channel index for div_load (out-of-range ignored)
//   div_val    : new divisor (period in clk cycles)
//   dout       : per-channel square wave
//   tick       : per-channel period-start strobe
//   pending    : per-channel shadow-divisor-waiting flag
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 12,
   localparam int unsigned CH_W       = idx_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              div_load,
   input  logic [CH_W-1:0]   div_ch,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] dout,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending
);

   // Per-channel write decode; indices >= NUM_CH match no channel.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ld;
      assign ld = div_load && (div_ch == CH_W'(i));

      clk_div_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[i]),
         .sync     (sync),
         .load     (ld),
         .load_val (div_val),
         .dout     (dout[i]),
         .tick     (tick[i]),
         .pending  (pending[i])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed vector table plus
// hand-written multi-cycle sequences.
module tb_clk_div_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  en;
   logic        sync;
   logic        div_load;
   logic [1:0]  div_ch;
   logic [15:0] div_val;
   logic [3:0]  dout, tick, pending;

   // Second instance with 3 channels so an out-of-range index is expressible.
   logic [2:0]  en3;
   logic        sync3;
   logic        div_load3;
   logic [1:0]  div_ch3;
   logic [15:0] div_val3;
   logic [2:0]  dout3, tick3, pending3;

   always #5 clk = ~clk;

   clk_div_gen #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(12)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_load(div_load),
      .div_ch(div_ch), .div_val(div_val), .dout(dout), .tick(tick), .pending(pending)
   );

   clk_div_gen #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .sync(sync3), .div_load(div_load3),
      .div_ch(div_ch3), .div_val(div_val3), .dout(dout3), .tick(tick3), .pending(pending3)
   );

   typedef struct packed {
      logic [3:0]  en;
      logic        sync;
      logic        ld;
      logic [1:0]  ch;
      logic [15:0] val;
      logic [3:0]  dout;
      logic [3:0]  tick;
      logic [3:0]  pend;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic [3:0] e, input logic s, input logic l, input logic [1:0] c,
                      input logic [15:0] v, input logic [3:0] d, input logic [3:0] t,
                      input logic [3:0] p);
      vec_t x;
      x.en = e; x.sync = s; x.ld = l; x.ch = c; x.val = v;
      x.dout = d; x.tick = t; x.pend = p;
      tbl.push_back(x);
   endtask

   task automatic chk3(input string name, input logic [3:0] d, input logic [3:0] t,
                       input logic [3:0] p);
      chk({name, " dout"}, 16'(dout), 16'(d));
      chk({name, " tick"}, 16'(tick), 16'(t));
      chk({name, " pend"}, 16'(pending), 16'(p));
   endtask

   initial begin
      logic [3:0] ed, et;
      rst_n = 1'b0; en = '0; sync = 1'b0; div_load = 1'b0; div_ch = '0; div_val = '0;
      en3 = '0; sync3 = 1'b0; div_load3 = 1'b0; div_ch3 = '0; div_val3 = '0;

      // Reset state
      repeat (2) cyc();
      chk3("reset", 4'b0000, 4'b0000, 4'b0000);
      chk("reset dut3 pend", 16'(pending3), 16'h0);
      rst_n = 1'b1;
      cyc();
      chk3("idle after release", 4'b0000, 4'b0000, 4'b0000);

      // Default divisor 12 on channel 0
      en = 4'b0001;
      for (int k = 0; k < 18; k++) begin
         cyc();
         chk3($sformatf("p12 k%0d", k), {3'b000, (k % 12) < 6}, {3'b000, (k % 12) == 0}, 4'b0000);
      end

      // Mid-period load of 5 (cnt 5->6), then period 5, then clamp of 0 and 1
      add(4'b0001, 0, 1, 2'd0, 16'd5, 4'b0000, 4'b0000, 4'b0001);
      for (int k = 0; k < 5; k++) add(4'b0001, 0, 0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0001);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      // load 0 on the wrap edge: period 2 immediately, no pending
      add(4'b0001, 0, 1, 0, 16'd0, 4'b0001, 4'b0001, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
      // load 1 mid-period: pending, then period 2
      add(4'b0001, 0, 1, 0, 16'd1, 4'b0000, 4'b0000, 4'b0001);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

      foreach (tbl[i]) begin
         en = tbl[i].en; sync = tbl[i].sync; div_load = tbl[i].ld;
         div_ch = tbl[i].ch; div_val = tbl[i].val;
         cyc();
         chk3($sformatf("vec%0d", i), tbl[i].dout, tbl[i].tick, tbl[i].pend);
      end
      div_load = 1'b0; sync = 1'b0;

      // Program 7/10 while disabled; ch1 load coincides with ch0 pending clear
      en = 4'b0000; div_load = 1'b1; div_ch = 2'd0; div_val = 16'd7;
      cyc(); chk3("dis ld7", 4'b0000, 4'b0000, 4'b0001);
      div_ch = 2'd1; div_val = 16'd10;
      cyc(); chk3("dis ld10", 4'b0000, 4'b0000, 4'b0010);
      div_load = 1'b0;
      cyc(); chk3("dis apply", 4'b0000, 4'b0000, 4'b0000);
      en = 4'b0011;
      cyc(); chk3("en 7/10", 4'b0011, 4'b0011, 4'b0000);
      for (int k = 1; k < 6; k++) begin
         cyc();
         ed = {2'b00, (k % 10) < 5, (k % 7) < 3};
         et = {2'b00, (k % 10) == 0, (k % 7) == 0};
         chk3($sformatf("7/10 k%0d", k), ed, et, 4'b0000);
      end
      // sync with ch1 load of 3: both align, ch1 new period starts now
      sync = 1'b1; div_load = 1'b1; div_ch = 2'd1; div_val = 16'd3;
      cyc(); chk3("sync ld3", 4'b0011, 4'b0011, 4'b0000);
      sync = 1'b0; div_load = 1'b0;
      for (int k = 1; k < 14; k++) begin
         cyc();
         ed = {2'b00, (k % 3) < 1, (k % 7) < 3};
         et = {2'b00, (k % 3) == 0, (k % 7) == 0};
         chk3($sformatf("7/3 k%0d", k), ed, et, 4'b0000);
      end
      // sync with a load to a disabled channel: pending for one cycle
      sync = 1'b1; div_load = 1'b1; div_ch = 2'd2; div_val = 16'd4;
      cyc(); chk3("sync dis ld", 4'b0011, 4'b0011, 4'b0100);
      sync = 1'b0; div_load = 1'b0;
      cyc(); chk3("dis ld apply", 4'b0001, 4'b0000, 4'b0000);

      // Mid-period async reset with a pending load
      en = 4'b0001; div_load = 1'b1; div_ch = 2'd0; div_val = 16'd9;
      cyc(); chk3("pre-rst ld", 4'b0001, 4'b0000, 4'b0001);
      div_load = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk3("async rst", 4'b0000, 4'b0000, 4'b0000);
      cyc();
      rst_n = 1'b1;
      chk3("rst release", 4'b0000, 4'b0000, 4'b0000);
      for (int k = 0; k < 13; k++) begin
         cyc();
         chk3($sformatf("post-rst k%0d", k), {3'b000, (k % 12) < 6},
              {3'b000, (k % 12) == 0}, 4'b0000);
      end
      en = 4'b0000;

      // Out-of-range channel index on the 3-channel instance (period 4)
      en3 = 3'b001;
      cyc(); chk("dut3 start tick", 16'(tick3), 16'h1);
      div_load3 = 1'b1; div_ch3 = 2'd3; div_val3 = 16'd9;
      cyc();
      chk("dut3 oor pend", 16'(pending3), 16'h0);
      div_load3 = 1'b0;
      for (int k = 2; k < 10; k++) begin
         cyc();
         chk($sformatf("dut3 tick k%0d", k), 16'(tick3), 16'((k % 4) == 0));
         chk($sformatf("dut3 pend k%0d", k), 16'(pending3), 16'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
